pcm_jitter_buffer: RTL and testbench

PCM_JITTER_BUFFER -- requirements
Module: pcm_jitter_buffer

---
 rtl/pcm_jitter_buffer_pkg.sv | 12 +
 rtl/pcm_fifo_mem.sv | 28 ++
 rtl/pcm_jitter_buffer.sv | 128 ++++++++++++
 tb/tb_pcm_jitter_buffer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pcm_jitter_buffer_pkg.sv
// Shared PCM definitions for the jitter buffer and the AC '97 PCM interface.
// Sample width and playout state encoding live here.
package pcm_jitter_buffer_pkg;

    localparam int PCM_W = 16;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_PLAY = 1'b1
    } pcm_state_e;

endpackage

// File: rtl/pcm_fifo_mem.sv
// Sample storage for the jitter buffer: synchronous write, asynchronous read.
// Maps onto distributed RAM; contents are never reset.
import pcm_jitter_buffer_pkg::*;

module pcm_fifo_mem #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [PCM_W-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [PCM_W-1:0]  o_rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [PCM_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pcm_jitter_buffer.sv
// Playout jitter buffer between a bursty network decoder and an 8 kHz codec.
// Holds playback until PREFILL samples are queued; drops back to FILL on underrun.
import pcm_jitter_buffer_pkg::*;

module pcm_jitter_buffer #(
    parameter int ADDR_W  = 8,
    parameter int PREFILL = 64
) (
    input  logic              clock_27mhz,
    input  logic              reset,
    input  logic              flush,
    input  logic [15:0]       wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic              ready,
    output logic [15:0]       audio_out_data,
    output logic              playing,
    output logic [ADDR_W:0]   level,
    output logic [15:0]       underrun_count
);

    localparam int              DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] LVL_FULL  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LVL_START = (ADDR_W + 1)'(PREFILL);
    localparam logic [ADDR_W:0] LVL_ONE   = (ADDR_W + 1)'(1);

    pcm_state_e          r_state;
    pcm_state_e          w_state_nxt;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [ADDR_W:0]     r_level;
    logic [ADDR_W:0]     w_level_nxt;
    logic [15:0]         r_underruns;
    logic [PCM_W-1:0]    w_head;
    logic                w_empty;
    logic                w_full;
    logic                w_play;
    logic                w_wr_en;
    logic                w_pop;
    logic                w_underrun;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == LVL_FULL);
    assign w_play  = (r_state == ST_PLAY) & ~reset;

    assign wr_ready = ~reset & ~flush & ~w_full;
    assign w_wr_en  = wr_valid & wr_ready;

    // Flush and reset both outrank a codec request.
    assign w_pop      = ready & w_play & ~flush & ~w_empty;
    assign w_underrun = ready & w_play & ~flush & w_empty;

    pcm_fifo_mem #(
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clock_27mhz),
        .i_we    (w_wr_en),
        .i_waddr (r_wr_ptr),
        .i_wdata (wr_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_head)
    );

    always_comb begin
        w_level_nxt = r_level;
        unique case ({w_wr_en, w_pop})
            2'b10:   w_level_nxt = r_level + LVL_ONE;
            2'b01:   w_level_nxt = r_level - LVL_ONE;
            default: w_level_nxt = r_level;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_FILL: begin
                if (!flush && r_level >= LVL_START) begin
                    w_state_nxt = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (flush || w_underrun) begin
                    w_state_nxt = ST_FILL;
                end
            end
            default: w_state_nxt = ST_FILL;
        endcase
    end

    always_ff @(posedge clock_27mhz) begin
        if (reset) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clock_27mhz) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_level <= w_level_nxt;
        end
    end

    // Counter survives flush so call-level statistics are not lost on resync.
    always_ff @(posedge clock_27mhz) begin
        if (reset) begin
            r_underruns <= '0;
        end else if (w_underrun && r_underruns != 16'hFFFF) begin
            r_underruns <= r_underruns + 16'd1;
        end
    end

    assign audio_out_data = (w_play & ~w_empty) ? w_head : 16'h0000;
    assign playing        = w_play;
    assign level          = r_level;
    assign underrun_count = r_underruns;

endmodule

// File: tb/tb_pcm_jitter_buffer.sv
// Directed bench for pcm_jitter_buffer.
// Prefill, order, underrun, full, simul, reset.
`timescale 1ns/1ps

module tb_pcm_jitter_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [15:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic        ready;
  logic [15:0] audio_out_data;
  logic        playing;
  logic [8:0]  level;
  logic [15:0] underrun_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pcm_jitter_buffer #(
    .ADDR_W  (8),
    .PREFILL (64)
  ) dut (
    .clock_27mhz    (clk),
    .reset          (reset),
    .flush          (flush),
    .wr_data        (wr_data),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .ready          (ready),
    .audio_out_data (audio_out_data),
    .playing        (playing),
    .level          (level),
    .underrun_count (underrun_count)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_n(
    input int          n,
    input logic [15:0] base
  );
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_data  = base + 16'(i);
      tick();
    end
    wr_valid = 1'b0;
  endtask

  task automatic pop_chk(
    input logic [15:0] exp,
    input string       tag
  );
    ready = 1'b1;
    #1;
    chk(tag, audio_out_data, exp);
    tick();
    ready = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    flush    = 1'b0;
    wr_data  = 16'h0000;
    wr_valid = 1'b0;
    ready    = 1'b0;
    #1;
    chk("rst_wr_ready", wr_ready, 1'b0);
    chk("rst_playing", playing, 1'b0);
    chk("rst_audio", audio_out_data, 16'h0);
    tick();
    tick();
    chk("rst_level", level, 9'd0);
    chk("rst_underruns", underrun_count, 16'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_wr_ready", wr_ready, 1'b1);

    write_n(63, 16'h0001);
    for (int i = 0; i < 3; i++) begin
      pop_chk(16'h0000, "fill_ready_audio");
      chk("fill_playing", playing, 1'b0);
    end
    chk("fill_level63", level, 9'd63);
    write_n(1, 16'h0040);
    chk("fill_level64", level, 9'd64);
    tick();
    chk("play_start", playing, 1'b1);

    for (int i = 1; i <= 64; i++) begin
      pop_chk(16'(i), "playout_order");
    end
    chk("playout_level0", level, 9'd0);
    chk("playout_still_play", playing, 1'b1);

    ready    = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 16'h0101;
    #1;
    chk("underrun_audio", audio_out_data, 16'h0);
    tick();
    ready    = 1'b0;
    wr_valid = 1'b0;
    chk("underrun_count1", underrun_count, 16'd1);
    chk("underrun_playing", playing, 1'b0);
    chk("underrun_wr_level", level, 9'd1);
    write_n(63, 16'h0102);
    chk("refill_level", level, 9'd64);
    tick();
    chk("refill_playing", playing, 1'b1);

    for (int i = 0; i < 54; i++) begin
      pop_chk(16'h0101 + 16'(i), "drain_order");
    end
    chk("drain_level10", level, 9'd10);
    ready    = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 16'h0200;
    #1;
    chk("simul_audio", audio_out_data, 16'h0137);
    tick();
    chk("simul_level", level, 9'd10);
    flush = 1'b1;
    #1;
    chk("flush_wr_ready", wr_ready, 1'b0);
    tick();
    flush    = 1'b0;
    ready    = 1'b0;
    wr_valid = 1'b0;
    chk("flush_level", level, 9'd0);
    chk("flush_playing", playing, 1'b0);
    chk("flush_underruns", underrun_count, 16'd1);
    tick();
    chk("flush_stays_fill", playing, 1'b0);

    write_n(256, 16'h0300);
    chk("full_level", level, 9'd256);
    chk("full_wr_ready", wr_ready, 1'b0);
    write_n(1, 16'hDEAD);
    chk("full_257_dropped", level, 9'd256);
    pop_chk(16'h0300, "full_pop_head");
    chk("full_pop_level", level, 9'd255);
    chk("full_pop_wr_ready", wr_ready, 1'b1);

    flush = 1'b1;
    tick();
    flush = 1'b0;
    write_n(100, 16'h0400);
    tick();
    chk("pre_rst_level", level, 9'd100);
    chk("pre_rst_playing", playing, 1'b1);
    reset = 1'b1;
    #1;
    chk("mid_rst_wr_ready", wr_ready, 1'b0);
    chk("mid_rst_playing", playing, 1'b0);
    chk("mid_rst_audio", audio_out_data, 16'h0);
    tick();
    chk("mid_rst_level", level, 9'd0);
    chk("mid_rst_underruns", underrun_count, 16'd0);
    chk("mid_rst_wr_ready_hold", wr_ready, 1'b0);
    reset = 1'b0;
    #1;
    chk("after_rst_wr_ready", wr_ready, 1'b1);
    tick();
    chk("after_rst_playing", playing, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
